// File: rtl/linear_diffusion_iter.sv
// linear_diffusion_iter: iterative Ascon linear layer, LANES words diffused per cycle; define LINEAR_DIFFUSION_BYPASS_EN to add bypass_i
module linear_diffusion_iter #(
  parameter int LANES = 5
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0][63:0] state_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [4:0][63:0] state_o
`ifdef LINEAR_DIFFUSION_BYPASS_EN
  ,
  input  logic            bypass_i
`endif
);
  generate
    if (LANES < 1 || LANES > 5) begin : gBadLanes
      $error("linear_diffusion_iter: LANES must be in 1..5");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsmState;
  localparam logic [2:0] STEP = 3'(LANES);
  localparam int R1 [5] = '{19, 61, 1, 10, 7};
  localparam int R2 [5] = '{28, 39, 6, 17, 41};
  fsmState fsm, fsmNext;
  logic [2:0] idx;
  logic [4:0][63:0] work, workNext;
  logic lastPass, bypass;
  function automatic logic [63:0] ror(input logic [63:0] x, input int r);
    return (x >> r) | (x << (64 - r));
  endfunction
  assign lastPass = int'(idx) + LANES >= 5;
`ifdef LINEAR_DIFFUSION_BYPASS_EN
  // bypass request is latched alongside the captured state
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) bypass <= 1'b0;
    else if (fsm == IDLE && valid_i) bypass <= bypass_i;
`else
  assign bypass = 1'b0;
`endif
  // diffuse only the words in the current lane window; all others hold
  always_comb begin
    workNext = work;
    for (int w = 0; w < 5; w++)
      workNext[w] = (!bypass && w >= int'(idx) && w < int'(idx) + LANES)
                    ? work[w] ^ ror(work[w], R1[w]) ^ ror(work[w], R2[w]) : work[w];
  end
  // state register
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) fsm <= IDLE;
    else fsm <= fsmNext;
  // next-state logic
  always_comb begin
    fsmNext = fsm;
    case (fsm)
      IDLE: fsmNext = valid_i ? BUSY : IDLE;
      BUSY: fsmNext = lastPass ? DONE : BUSY;
      DONE: fsmNext = ready_i ? IDLE : DONE;
      default: fsmNext = IDLE;
    endcase
  end
  // working register: capture in IDLE, advance one lane window per BUSY cycle
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      work <= '0;
      idx <= '0;
    end else if (fsm == IDLE && valid_i) begin
      work <= state_i;
      idx <= '0;
    end else if (fsm == BUSY) begin
      work <= workNext;
      idx <= idx + STEP;
    end
  // handshake outputs decoded from the FSM state
  always_comb begin
    ready_o = fsm == IDLE;
    valid_o = fsm == DONE;
    state_o = work;
  end
endmodule
